kernel_pio_ctrl: RTL and testbench
==================================

Name: kernel_pio_ctrl

Overview:
Parametrised Avalon-MM slave PIO for the CNN Nios subsystem. Generalises the single-bit output register to DATA_WIDTH output bits and adds a DATA_WIDTH input port with edge capture and interrupt. Also adds set/clear write aliases and a programmable auto-clear pulse mode. The Nios uses it to start CNN kernel runs and to collect done/error flags from the accelerator.

Parameters:
DATA_WIDTH, 8, width of out_port, in_port and all data registers (1..32)
RESET_VALUE, 0, reset value of the output data register (DATA_WIDTH bits)
PULSE_WIDTH, 4, cycles an auto-clear bit stays high after being set (1..255)

Ports:
clk  input  1  system clock
reset_n  input  1  reset, asynchronous assert, active-low
address  input  3  register word address
chipselect  input  1  slave select
write_n  input  1  write strobe, active-low
writedata  input  32  write data; bits above DATA_WIDTH ignored
readdata  output  32  read data, combinational from address; upper bits zero
in_port  input  DATA_WIDTH  status inputs from CNN kernel (synchronous to clk)
out_port  output  DATA_WIDTH  control outputs to CNN kernel
irq  output  1  level interrupt, active-high

Behaviour:
- Reset (reset_n=0, asynchronous):
  - data_out = RESET_VALUE; irq_mask = 0; edge_cap = 0; pulse_mask = 0.
  - All pulse counters = 0; in_port delay register = 0.
- Register map. A write is chipselect && !write_n.
  - addr0 DATA: read {in_port}; write loads data_out.
  - addr1 OUT: read data_out; write has no effect.
  - addr2 IRQMASK: R/W.
  - addr3 EDGECAP: read edge_cap; writing a 1 to a bit clears that bit.
  - addr4 OUTSET: write ORs writedata into data_out; reads 0.
  - addr5 OUTCLR: write clears data_out bits where writedata=1; reads 0.
  - addr6 PULSEMASK: R/W; marks which out bits auto-clear.
  - addr7: reads 0, write ignored.
- Output update:
  - The data_out update is visible on out_port the cycle after the write edge (latency 1).
- Edge capture:
  - in_d <= in_port every cycle.
  - Rising edge on bit i is in_port[i] & ~in_d[i]; it sets edge_cap[i] the next cycle.
  - Simultaneous edge and clear-write on the same bit: set wins, bit stays 1.
- irq = |(edge_cap & irq_mask), registered-free combinational from the flops.
- Pulse mode:
  - Each bit with pulse_mask[i]=1 has an 8-bit counter.
  - When data_out[i] transitions 0->1 by any write, the counter loads PULSE_WIDTH-1.
  - While the counter is >0 it decrements each cycle.
  - When the counter is 0 and data_out[i]=1 and pulse_mask[i]=1, data_out[i] clears next cycle.
  - The bit is therefore high for exactly PULSE_WIDTH cycles.
  - Rewriting 1 while the bit is already high does not restart the count.
  - A write clearing the bit mid-pulse clears it immediately and zeroes the counter.
  - Clearing pulse_mask[i] mid-pulse freezes auto-clear; the bit holds its value.
  - Simultaneous auto-clear and a write setting the same bit: the write wins and the counter reloads.
- Reset mid-pulse: the output returns to RESET_VALUE immediately and the counters zero.

Optional Feature:
KERNEL_PIO_SYNC_EN:
- Defined: in_port passes through a 2-flop synchroniser (reset 0) before in_d and the DATA read path. Edge-to-capture latency becomes 3 cycles, and DATA reads return the synchronised value.
- Undefined: no synchroniser; latency is 1 cycle as above.

Test Plan:
- Reset with RESET_VALUE=8'hA5 -> out_port=8'hA5, irq=0, reads of addr2/3/6 = 0.
- Write addr0 0x3C, then addr4 0x01, then addr5 0x0C -> out_port sequence 0x3C, 0x3D, 0x31; addr1 reads 0x31.
- irq_mask=0x02; in_port bit1 goes 0->1 -> edge_cap=0x02 after 1 cycle, irq=1; write addr3 0x02 -> irq=0. Repeat with the edge in the same cycle as the clear -> edge_cap stays 0x02.
- pulse_mask=0x01, PULSE_WIDTH=4; write addr4 0x01 -> out_port[0] high exactly 4 cycles, then 0; other bits are unaffected.
- Mid-pulse write addr5 0x01 at cycle 2 -> bit 0 low next cycle. Mid-pulse assert reset_n=0 -> out_port=RESET_VALUE asynchronously.
- With KERNEL_PIO_SYNC_EN defined: in_port edge -> edge_cap set 3 cycles later; without it, 1 cycle later.

Source files
------------

// File: rtl/kernel_pio_ctrl.sv
// kernel_pio_ctrl: Avalon-MM PIO, DATA_WIDTH outputs with set/clear aliases and auto-clear pulses, DATA_WIDTH inputs with edge capture and irq.
// Latency: register writes visible on out_port 1 cycle after the write edge; in_port edge captured 1 cycle later (3 with KERNEL_PIO_SYNC_EN).
// Backpressure: none; the slave accepts every access with zero wait states and readdata is combinational from address.
module kernel_pio_ctrl #(
   parameter int                    DATA_WIDTH  = 8,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
   parameter int                    PULSE_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [2:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   input  logic [DATA_WIDTH-1:0] in_port,
   output logic [DATA_WIDTH-1:0] out_port,
   output logic                  irq
);

   // Counter load value: the bit stays high for the load cycle plus PW_M1 more.
   localparam logic [7:0] PW_M1 = 8'(PULSE_WIDTH - 1);

   logic                  wr_en;
   logic [DATA_WIDTH-1:0] wd;
   logic [DATA_WIDTH-1:0] data_out;
   logic [DATA_WIDTH-1:0] data_nxt;
   logic [DATA_WIDTH-1:0] irq_mask;
   logic [DATA_WIDTH-1:0] edge_cap;
   logic [DATA_WIDTH-1:0] pulse_mask;
   logic [DATA_WIDTH-1:0] in_src;
   logic [DATA_WIDTH-1:0] in_d;
   logic [DATA_WIDTH-1:0] rise;
   logic [DATA_WIDTH-1:0] wr_set;
   logic [DATA_WIDTH-1:0] wr_clr;
   logic [DATA_WIDTH-1:0] auto_clr;
   logic [DATA_WIDTH-1:0] cnt_dec;
   logic [DATA_WIDTH-1:0] rd_val;
   logic [7:0]            cnt     [DATA_WIDTH];
   logic [7:0]            cnt_nxt [DATA_WIDTH];

   assign wr_en = chipselect & ~write_n;
   assign wd    = writedata[DATA_WIDTH-1:0];

   // Upper write-data bits carry no register state.
   generate
      if (DATA_WIDTH < 32) begin : g_wd_unused
         logic unused_wd_hi;
         assign unused_wd_hi = ^writedata[31:DATA_WIDTH];
      end
   endgenerate

`ifdef KERNEL_PIO_SYNC_EN
   logic [DATA_WIDTH-1:0] sync1;
   logic [DATA_WIDTH-1:0] sync2;

   // Two-flop synchroniser for status inputs crossing in from the kernel.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= in_port;
         sync2 <= sync1;
      end
   end

   assign in_src = sync2;
`else
   assign in_src = in_port;
`endif

   assign rise = in_src & ~in_d;

   // Input delay, edge capture (a new edge beats a simultaneous clear) and mask registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         in_d       <= '0;
         edge_cap   <= '0;
         irq_mask   <= '0;
         pulse_mask <= '0;
      end else begin
         in_d <= in_src;
         if (wr_en && address == 3'd3) begin
            edge_cap <= (edge_cap & ~wd) | rise;
         end else begin
            edge_cap <= edge_cap | rise;
         end
         if (wr_en && address == 3'd2) begin
            irq_mask <= wd;
         end
         if (wr_en && address == 3'd6) begin
            pulse_mask <= wd;
         end
      end
   end

   // Decode which output bits this write forces high and which it forces low.
   always_comb begin
      wr_set = '0;
      wr_clr = '0;
      if (wr_en) begin
         case (address)
            3'd0: begin
               wr_set = wd;
               wr_clr = ~wd;
            end
            3'd4:    wr_set = wd;
            3'd5:    wr_clr = wd;
            default: ;
         endcase
      end
   end

   // Per-bit output and pulse counter next state: write clear, then write set, then auto-clear.
   always_comb begin
      data_nxt = data_out;
      auto_clr = '0;
      cnt_dec  = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         cnt_nxt[i]  = cnt[i];
         auto_clr[i] = pulse_mask[i] & data_out[i] & (cnt[i] == 8'd0);
         cnt_dec[i]  = pulse_mask[i] & (cnt[i] != 8'd0);
         if (wr_clr[i]) begin
            data_nxt[i] = 1'b0;
            cnt_nxt[i]  = 8'd0;
         end else if (wr_set[i]) begin
            data_nxt[i] = 1'b1;
            // Only a fresh rise, or a set racing the auto-clear, restarts the pulse.
            if (!data_out[i] || auto_clr[i]) begin
               cnt_nxt[i] = PW_M1;
            end else if (cnt_dec[i]) begin
               cnt_nxt[i] = cnt[i] - 8'd1;
            end
         end else if (auto_clr[i]) begin
            data_nxt[i] = 1'b0;
         end else if (cnt_dec[i]) begin
            cnt_nxt[i] = cnt[i] - 8'd1;
         end
      end
   end

   // Output data register and pulse counters.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out <= RESET_VALUE;
         for (int i = 0; i < DATA_WIDTH; i++) begin
            cnt[i] <= 8'd0;
         end
      end else begin
         data_out <= data_nxt;
         for (int i = 0; i < DATA_WIDTH; i++) begin
            cnt[i] <= cnt_nxt[i];
         end
      end
   end

   // Read mux; alias and unused addresses read as zero.
   always_comb begin
      rd_val = '0;
      case (address)
         3'd0:    rd_val = in_src;
         3'd1:    rd_val = data_out;
         3'd2:    rd_val = irq_mask;
         3'd3:    rd_val = edge_cap;
         3'd6:    rd_val = pulse_mask;
         default: rd_val = '0;
      endcase
      readdata = 32'(rd_val);
   end

   assign out_port = data_out;
   assign irq      = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_kernel_pio_ctrl.sv
// tb_kernel_pio_ctrl: directed stimulus for kernel_pio_ctrl with a cycle-tagged scoreboard.
// Stimulus pushes expected values tagged with the cycle they must hold; a negedge monitor pops and compares.
// Edge latency follows KERNEL_PIO_SYNC_EN so the same bench covers both builds.
module tb_kernel_pio_ctrl;

   localparam int         DW = 8;
   localparam logic [7:0] RV = 8'hA5;
`ifdef KERNEL_PIO_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   localparam int K_OUT = 0;
   localparam int K_IRQ = 1;
   localparam int K_RD  = 2;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [2:0]    address;
   logic          chipselect;
   logic          write_n;
   logic [31:0]   writedata;
   logic [31:0]   readdata;
   logic [DW-1:0] in_port;
   logic [DW-1:0] out_port;
   logic          irq;

   kernel_pio_ctrl #(
      .DATA_WIDTH (DW),
      .RESET_VALUE(RV),
      .PULSE_WIDTH(4)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .address   (address),
      .chipselect(chipselect),
      .write_n   (write_n),
      .writedata (writedata),
      .readdata  (readdata),
      .in_port   (in_port),
      .out_port  (out_port),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      int             due;
      int             kind;
      logic [31:0]    exp;
      logic [8*12-1:0] name;
   } chk_t;

   chk_t        sb[$];
   chk_t        mc;
   logic [31:0] act;
   int          tests = 0;
   int          fails = 0;
   int          n;

   task automatic expect_at(input int due, input int kind, input logic [31:0] exp,
                            input logic [8*12-1:0] name);
      chk_t c;
      c.due  = due;
      c.kind = kind;
      c.exp  = exp;
      c.name = name;
      sb.push_back(c);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] exp, input logic [8*12-1:0] name);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      expect_at(cyc, K_RD, exp, name);
      tick();
      chipselect = 1'b0;
   endtask

   // Monitor: compare every scoreboard entry due in the current cycle.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         mc = sb.pop_front();
         if (mc.kind == K_OUT)      act = {24'd0, out_port};
         else if (mc.kind == K_IRQ) act = {31'd0, irq};
         else                       act = readdata;
         tests = tests + 1;
         if (mc.due != cyc) begin
            fails = fails + 1;
            $display("FAIL %s: due cycle %0d missed, now cycle %0d", mc.name, mc.due, cyc);
         end else if (act !== mc.exp) begin
            fails = fails + 1;
            $display("FAIL %s: cycle %0d actual %h required %h", mc.name, cyc, act, mc.exp);
         end
      end
   end

   initial begin
      reset_n    = 1'b0;
      address    = '0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      in_port    = '0;

      // Reset state
      tick();
      tick();
      expect_at(cyc, K_OUT, 32'hA5, "rst_out");
      expect_at(cyc, K_IRQ, 32'h0, "rst_irq");
      tick();
      reset_n = 1'b1;
      tick();
      rd(3'd2, 32'h0, "rst_irqmask");
      rd(3'd3, 32'h0, "rst_edgecap");
      rd(3'd6, 32'h0, "rst_pulsemsk");
      rd(3'd1, 32'hA5, "rd_out_rv");

      // DATA write, OUTSET, OUTCLR
      wr(3'd0, 32'hFFFF_FF3C);
      expect_at(cyc, K_OUT, 32'h3C, "wr_data");
      wr(3'd4, 32'h0000_0001);
      expect_at(cyc, K_OUT, 32'h3D, "wr_outset");
      wr(3'd5, 32'h0000_000C);
      expect_at(cyc, K_OUT, 32'h31, "wr_outclr");
      rd(3'd1, 32'h31, "rd_out");
      rd(3'd4, 32'h0, "rd_outset");
      rd(3'd5, 32'h0, "rd_outclr");
      rd(3'd7, 32'h0, "rd_addr7");
      wr(3'd1, 32'h0000_00FF);
      expect_at(cyc, K_OUT, 32'h31, "wr_addr1");
      wr(3'd7, 32'h0000_00FF);
      expect_at(cyc, K_OUT, 32'h31, "wr_addr7");

      // DATA read path returns in_port (through the synchroniser when enabled)
      in_port = 8'h80;
      repeat (LAT + 1) tick();
      rd(3'd0, 32'h80, "rd_data");
      in_port = 8'h00;
      repeat (LAT + 1) tick();
      wr(3'd3, 32'h0000_00FF);
      rd(3'd3, 32'h0, "ecap_flush");

      // Edge capture and irq
      wr(3'd2, 32'h0000_0002);
      rd(3'd2, 32'h02, "irqmask_rb");
      in_port = 8'h02;
      n = cyc;
      for (int k = 0; k <= LAT; k++) begin
         expect_at(n + k, K_IRQ, (k == LAT) ? 32'h1 : 32'h0, "irq_edge");
      end
      repeat (LAT) tick();
      rd(3'd3, 32'h02, "ecap_set");
      wr(3'd3, 32'h0000_0002);
      expect_at(cyc, K_IRQ, 32'h0, "irq_clr");
      rd(3'd3, 32'h0, "ecap_clr");

      // Edge arriving on the same edge as the clear write: set wins
      in_port = 8'h00;
      repeat (LAT + 2) tick();
      in_port = 8'h02;
      repeat (LAT - 1) tick();
      wr(3'd3, 32'h0000_0002);
      expect_at(cyc, K_IRQ, 32'h1, "irq_setwin");
      rd(3'd3, 32'h02, "ecap_setwin");
      wr(3'd3, 32'h0000_0002);
      rd(3'd3, 32'h0, "ecap_clr2");
      wr(3'd2, 32'h0);

      // Pulse mode, PULSE_WIDTH = 4
      wr(3'd0, 32'h30);
      wr(3'd6, 32'h01);
      rd(3'd6, 32'h01, "pmask_rb");
      wr(3'd4, 32'h01);
      n = cyc;
      for (int k = 0; k < 4; k++) expect_at(n + k, K_OUT, 32'h31, "pulse_hi");
      expect_at(n + 4, K_OUT, 32'h30, "pulse_lo");
      expect_at(n + 5, K_OUT, 32'h30, "pulse_lo2");
      repeat (6) tick();

      // Rewriting 1 while high does not restart the count
      wr(3'd4, 32'h01);
      n = cyc;
      wr(3'd4, 32'h01);
      expect_at(n + 3, K_OUT, 32'h31, "rewr_hi");
      expect_at(n + 4, K_OUT, 32'h30, "rewr_lo");
      repeat (5) tick();

      // Set racing the auto-clear wins and reloads the counter
      wr(3'd4, 32'h01);
      n = cyc;
      repeat (3) tick();
      wr(3'd4, 32'h01);
      for (int k = 4; k < 8; k++) expect_at(n + k, K_OUT, 32'h31, "race_hi");
      expect_at(n + 8, K_OUT, 32'h30, "race_lo");
      repeat (6) tick();

      // Mid-pulse clear write
      wr(3'd4, 32'h01);
      n = cyc;
      tick();
      wr(3'd5, 32'h01);
      expect_at(n + 2, K_OUT, 32'h30, "midclr");
      repeat (4) tick();
      expect_at(cyc, K_OUT, 32'h30, "midclr_hold");
      tick();

      // Clearing pulse_mask mid-pulse freezes the auto-clear
      wr(3'd4, 32'h01);
      wr(3'd6, 32'h00);
      repeat (6) tick();
      expect_at(cyc, K_OUT, 32'h31, "freeze_hold");
      tick();
      wr(3'd6, 32'h01);
      n = cyc;
      for (int k = 0; k < 3; k++) expect_at(n + k, K_OUT, 32'h31, "unfrz_hi");
      expect_at(n + 3, K_OUT, 32'h30, "unfrz_lo");
      repeat (5) tick();

      // Reset mid-pulse returns the output to RESET_VALUE at once
      wr(3'd4, 32'h01);
      tick();
      reset_n = 1'b0;
      #1;
      expect_at(cyc, K_OUT, 32'hA5, "rst_mid");
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      expect_at(cyc, K_OUT, 32'hA5, "rst_after");
      rd(3'd6, 32'h0, "rst_pmask2");
      rd(3'd2, 32'h0, "rst_imask2");
      repeat (6) tick();
      expect_at(cyc, K_OUT, 32'hA5, "rst_hold");
      tick();

      // Drain the scoreboard within a bounded number of cycles
      for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
      while (sb.size() > 0) begin
         mc = sb.pop_front();
         tests = tests + 1;
         fails = fails + 1;
         $display("FAIL %s: never checked, due cycle %0d", mc.name, mc.due);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
